// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state encoding and the default bit period.
// The transmitter and the receiver both import this package.
package uart_pkg;

    // 50 MHz system clock divided down to 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // Frame state encoding, kept as plain constants so the receiver can reuse them
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-slot timer for the UART: a loadable down-counter that flags the last
// cycle of a serial bit slot. Loading N-1 gives a slot of N cycles.
module uart_bit_timer #(
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_run,
    output logic             o_bit_end
);

    logic [WIDTH-1:0] count;

    // Count down from the loaded value and rest at zero once the slot has elapsed
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_value;
        end else if (i_clear) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // Flag the final cycle of the current slot, but only while a frame is running
    always_comb begin
        o_bit_end = i_run && (count == '0);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter for the debug path: takes one byte per start request and
// sends it LSB first as start / data / [parity] / stop on a registered line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    // The timer must hold the longest slot, which is the whole stop period
    localparam int CNT_W  = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);
    localparam int SECOND = (DATA_BITS > 1) ? 1 : 0;

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(DATA_BITS);

    uart_state_t state;
    uart_state_t state_next;

    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_index;
    logic                 tx_q;
    logic                 line_next;
    logic                 armed;
    logic                 accept;

    logic                 bit_end;
    logic                 timer_clear;
    logic                 timer_load;
    logic [CNT_W-1:0]     timer_value;

`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // A request is taken only in IDLE and never on the edge that releases reset
    assign accept = armed && i_tx_start && (state == IDLE);
    assign o_tx   = tx_q;

    uart_bit_timer #(
        .WIDTH(CNT_W)
    ) bit_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (timer_clear),
        .i_load      (timer_load),
        .i_load_value(timer_value),
        .i_run       (state != IDLE),
        .o_bit_end   (bit_end)
    );

    // State register; reset drops any frame in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, which also restarts the bit timer on every state entry
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        timer_load  = 1'b0;
        timer_value = BIT_LOAD;
        case (state)
            IDLE: begin
                timer_clear = !accept;
                if (accept) begin
                    state_next = START;
                    timer_load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    timer_load = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_load = 1'b1;
                    if (bit_index == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next  = STOP;
                        timer_value = STOP_LOAD;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (bit_end) begin
                    state_next  = STOP;
                    timer_load  = 1'b1;
                    timer_value = STOP_LOAD;
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs and the line level to be registered for the coming cycle
    always_comb begin
        o_busy    = (state != IDLE);
        o_tx_done = (state == STOP) && bit_end;
        line_next = 1'b1;
        case (state_next)
            START: begin
                line_next = 1'b0;
            end
            DATA: begin
                if ((state == DATA) && bit_end) begin
                    line_next = shift_reg[SECOND];
                end else begin
                    line_next = shift_reg[0];
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                line_next = parity_bit;
`else
                line_next = 1'b1;
`endif
            end
            default: begin
                line_next = 1'b1;
            end
        endcase
    end

    // Datapath: byte capture, shifting, bit index, and the glitch-free line register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_reg <= '0;
            bit_index <= '0;
            tx_q      <= 1'b1;
            armed     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            tx_q  <= line_next;
            if (accept) begin
                shift_reg <= i_tx_data;
                bit_index <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^i_tx_data;
`endif
            end else if ((state == DATA) && bit_end) begin
                shift_reg <= shift_reg >> 1;
                if (bit_index != FULL_IDX) begin
                    bit_index <= bit_index + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx with CLKS_PER_BIT=4 and STOP_BITS=1.
// Stimulus pushes expected frames; a monitor captures each frame from the line
// and compares it. Build with UART_TX_PARITY_EN to cover the parity variant.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = (1 + 8 + PAR + 1) * CPB;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        int         gap;
    } expect_t;

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_line;
    logic       busy;
    logic       tx_done;

    expect_t exp_q[$];
    int      checks_total;
    int      checks_passed;

    logic [FRAME_LEN-1:0] line_s;
    logic [FRAME_LEN-1:0] done_s;
    logic [FRAME_LEN-1:0] busy_s;
    logic [FRAME_LEN-1:0] done_exp;
    logic [7:0]           decoded;
    int                   idle_run;
    bit                   aborted;
    bit                   saw_done;
    logic                 post_busy;
    logic                 post_done;
    logic                 post_tx;
    expect_t              cur;

    uart_tx #(
        .DATA_BITS   (8),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_tx_start(tx_start),
        .i_tx_data (tx_data),
        .o_tx      (tx_line),
        .o_busy    (busy),
        .o_tx_done (tx_done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected line level for every cycle of a frame, built slot by slot
    function automatic logic [FRAME_LEN-1:0] expected_line(input logic [7:0] d, input logic par);
        logic [FRAME_LEN-1:0] v;
        int slot;
        v = '1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            slot = k / CPB;
            if (slot == 0) begin
                v[k] = 1'b0;
            end else if (slot <= 8) begin
                v[k] = d[slot-1];
            end else if ((PAR == 1) && (slot == 9)) begin
                v[k] = par;
            end else begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Issue one start pulse; optionally record the frame it should produce
    task automatic apply_stimulus(input logic [7:0] data, input logic par, input int gap, input bit push);
        expect_t item;
        @(posedge clk);
        #2;
        tx_data  = data;
        tx_start = 1'b1;
        if (push) begin
            item.data   = data;
            item.parity = par;
            item.gap    = gap;
            exp_q.push_back(item);
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check_output("accept_busy", busy, 1);
        check_output("accept_line_low", tx_line, 0);
    endtask

    task automatic wait_frame_end();
        int  n;
        bit  ended;
        n     = 0;
        ended = 0;
        while ((n < 200) && !ended) begin
            @(posedge clk);
            #1;
            if (!busy) ended = 1;
            n++;
        end
        check_output("frame_end_in_time", ended, 1);
    endtask

    // Monitor: capture each frame at falling edges and compare it with the scoreboard
    initial begin : monitor
        idle_run = 0;
        done_exp = '0;
        done_exp[FRAME_LEN-1] = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idle_run = 0;
            end else if (!busy) begin
                idle_run++;
            end else begin
                aborted  = 0;
                saw_done = 0;
                line_s   = '1;
                done_s   = '0;
                busy_s   = '0;
                for (int k = 0; k < FRAME_LEN; k++) begin
                    if (k != 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                    line_s[k] = tx_line;
                    done_s[k] = tx_done;
                    busy_s[k] = busy;
                    if (tx_done) saw_done = 1;
                end
                if (aborted) begin
                    check_output("aborted_frame_no_done", saw_done, 0);
                    idle_run = 0;
                end else begin
                    @(negedge clk);
                    post_busy = busy;
                    post_done = tx_done;
                    post_tx   = tx_line;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_frame", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check_output("frame_line", line_s, expected_line(cur.data, cur.parity));
                        for (int i = 0; i < 8; i++) begin
                            decoded[i] = line_s[(1 + i) * CPB + CPB / 2];
                        end
                        check_output("frame_byte", decoded, cur.data);
                        if (PAR == 1) begin
                            check_output("frame_parity", line_s[9 * CPB + CPB / 2], cur.parity);
                        end
                        check_output("frame_done_pulse", done_s, done_exp);
                        check_output("frame_busy", busy_s, {FRAME_LEN{1'b1}});
                        check_output("frame_after", {post_busy, post_done, post_tx}, 3'b001);
                        if (cur.gap >= 0) begin
                            check_output("frame_gap", idle_run, cur.gap);
                        end
                    end
                    idle_run = post_busy ? 0 : 1;
                end
            end
        end
    end

    // Directed scenarios
    initial begin : stimulus
        int rises;
        bit prev_busy;
        checks_total  = 0;
        checks_passed = 0;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // Reset state, then idle for 20 cycles
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_line", tx_line, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", tx_done, 0);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("idle_line", tx_line, 1);
        check_output("idle_busy", busy, 0);
        check_output("idle_done", tx_done, 0);

        // Plain frame: 0x73 has five ones, so even parity is 1
        apply_stimulus(8'h73, 1'b1, -1, 1);
        wait_frame_end();
        repeat (3) @(posedge clk);

        // New data and a second start mid-frame must not disturb the frame
        apply_stimulus(8'h73, 1'b1, -1, 1);
        repeat (10) @(posedge clk);
        #2;
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_frame_end();
        repeat (3) @(posedge clk);

        // Start held high: three 0xA5 frames (four ones, parity 0), one idle cycle apart
        @(posedge clk);
        #2;
        exp_q.push_back('{data: 8'hA5, parity: 1'b0, gap: -1});
        exp_q.push_back('{data: 8'hA5, parity: 1'b0, gap: 1});
        exp_q.push_back('{data: 8'hA5, parity: 1'b0, gap: 1});
        tx_data   = 8'hA5;
        tx_start  = 1'b1;
        rises     = 0;
        prev_busy = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            if (rises == 3) break;
        end
        tx_start = 1'b0;
        check_output("held_start_frames", rises, 3);
        wait_frame_end();
        repeat (3) @(posedge clk);

        // Reset in cycle 15 of a 0x00 frame drops it at once
        apply_stimulus(8'h00, 1'b0, -1, 0);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("midreset_line", tx_line, 1);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        apply_stimulus(8'h00, 1'b0, -1, 1);
        wait_frame_end();
        repeat (3) @(posedge clk);

        // 0x03 has two ones, so even parity is 0
        apply_stimulus(8'h03, 1'b0, -1, 1);
        wait_frame_end();
        repeat (5) @(posedge clk);

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the debug path. Accepts one byte per handshake from the debug unit (`o_uart_tx_data` / `o_uart_tx_ready` there) and shifts it out as an 8N1-style frame on the board TX pin. It returns a one-cycle completion pulse that feeds the debug unit's `i_uart_tx_done`. This is the transmit end of the same UART link whose receiver delivers the `i_uart_rx_ready` / `i_uart_rx_data` commands.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame.
- `CLKS_PER_BIT`, 5208: `i_clk` cycles per serial bit (50 MHz / 9600 baud); legal range ≥2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_tx_start`  in  1  request to send `i_tx_data`; sampled only in IDLE.
- `i_tx_data`  in  DATA_BITS  byte to send; captured on the accepting edge.
- `o_tx`  out  1  serial line; idle high.
- `o_busy`  out  1  high from the accepting edge until the frame completes.
- `o_tx_done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `o_tx`=1, `o_busy`=0. On `i_tx_start`=1:
  - latch `i_tx_data` into the shift register;
  - clear the bit-cycle counter and bit index;
  - go to START.
- START: `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `o_tx` = shift register bit 0 (LSB first). Shift right every `CLKS_PER_BIT` cycles. After `DATA_BITS` bits, go to PARITY or STOP.
- STOP: `o_tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles. On the final cycle, assert `o_tx_done` and return to IDLE.
- Counters:
  - bit-cycle counter is `$clog2(CLKS_PER_BIT*STOP_BITS)` bits wide and counts 0..N-1, restarting at each state entry;
  - bit index is `$clog2(DATA_BITS+1)` bits wide and never wraps past `DATA_BITS`.
- `i_tx_start` outside IDLE is ignored. It is not queued, and `i_tx_data` changes do not affect the frame in flight.
- `o_tx` is registered, so the line never glitches.

## Timing
- Reset values: `o_tx`=1, `o_busy`=0, `o_tx_done`=0, state IDLE. Reset takes effect immediately and asynchronously.
- Reset mid-frame: line returns high at once, no `o_tx_done` pulse, and the frame is dropped.
- Accept at edge T0: `o_tx` falls and `o_busy` rises after T0.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- `o_tx_done` is high during cycle T0+F−1 to T0+F. It coincides with the last stop-bit cycle. `o_busy` falls at the same edge the pulse ends.
- Back-to-back: `i_tx_start`=1 while `o_tx_done`=1 is not accepted, because the state is still STOP. The earliest accept is the first IDLE cycle, giving a minimum gap of 1 cycle of idle-high between frames.
- A simultaneous reset deassertion and `i_tx_start` on the same edge is not accepted. Accept starts on the next edge.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted after DATA;
  - `o_tx` = XOR of the latched byte (even parity) for `CLKS_PER_BIT` cycles;
  - F grows by `CLKS_PER_BIT`.
- Macro undefined: DATA goes directly to STOP. No parity logic is synthesized.

## Structure
- Shared package `uart_pkg`: state encoding localparams (IDLE/START/DATA/PARITY/STOP) and the default `CLKS_PER_BIT`. The same package is also used by the UART receiver.
- One sub-module, `uart_bit_timer`: loadable down-counter with clear and a `o_bit_end` pulse. `uart_tx` instantiates it once.
- Everything else (FSM, shift register, bit index, parity) stays in `uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `STOP_BITS`=1.
- Reset low, then high: `o_tx`=1, `o_busy`=0, `o_tx_done`=0. After 20 idle cycles, still unchanged.
- `i_tx_start` pulse with `i_tx_data`=0x73:
  - line shows 0, then 1,1,0,0,1,1,1,0 (LSB first), then 1, each held 4 cycles;
  - `o_tx_done` is a single pulse at cycle 39 after accept;
  - `o_busy` is high for exactly 40 cycles.
- `i_tx_data` changed to 0xFF and `i_tx_start` re-pulsed mid-frame: the frame still carries 0x73, and only one `o_tx_done` pulse occurs.
- `i_tx_start` held high continuously with 0xA5: frames repeat, separated by exactly 1 idle-high cycle, and there is one `o_tx_done` per frame.
- `i_reset` asserted at cycle 15 of a 0x00 frame: `o_tx`=1 immediately, `o_busy`=0, no `o_tx_done`. The next request sends a complete, correct frame.
- With `UART_TX_PARITY_EN`:
  - 0x73 (five 1s) gives a parity bit of 1;
  - 0x03 gives a parity bit of 0;
  - `o_tx_done` occurs at cycle 43.
